// File: rtl/amplitude_detector.sv
// amplitude_detector: I/Q magnitude front end feeding the averager.
//   Stage 1: |I|, |Q| (the most negative input maps exactly to 2^(NBITS-1)).
//   Stage 2: alpha-max-beta-min magnitude, mag = max + 3/8 * min.
//   Stage 3: window of 2^WBITS valid samples reduced to one amplitude word,
//            qualified by a one-cycle next strobe.
// Optional feature macro: AMPLITUDE_DETECTOR_PEAK_EN
//   defined   -> window result is the peak magnitude
//   undefined -> window result is the truncated mean magnitude (default)
module amplitude_detector #(
    parameter int NBITS = 16,
    parameter int WBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [NBITS-1:0] i_data,
    input  logic [NBITS-1:0] q_data,
    output logic [NBITS-1:0] amplitude,
    output logic             next,
    output logic [WBITS-1:0] win_pos
);

    // ------------------------------------------------------------------
    // Stage 1: absolute values
    // ------------------------------------------------------------------
    logic [NBITS-1:0] w_ai;
    logic [NBITS-1:0] w_aq;
    logic [NBITS-1:0] r_ai;
    logic [NBITS-1:0] r_aq;
    logic             r_v1;

    // Two's-complement negate when the sign bit is set; read as unsigned the
    // most negative value negates onto itself, which is exactly 2^(NBITS-1).
    always_comb begin
        w_ai = i_data;
        w_aq = q_data;
        if (i_data[NBITS-1]) w_ai = ~i_data + NBITS'(1);
        if (q_data[NBITS-1]) w_aq = ~q_data + NBITS'(1);
    end

    // Register absolute values and their valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_ai <= '0;
            r_aq <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_ai <= w_ai;
                r_aq <= w_aq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude approximation
    // ------------------------------------------------------------------
    logic [NBITS-1:0] w_mx;
    logic [NBITS-1:0] w_mn;
    logic [NBITS-1:0] w_mag;
    logic [NBITS-1:0] r_mag;
    logic             r_v2;

    // Sort the two absolute values and form max + min/4 + min/8; the worst
    // case of 1.375 * 2^(NBITS-1) still fits in NBITS bits.
    always_comb begin
        w_mx = r_ai;
        w_mn = r_aq;
        if (r_aq > r_ai) begin
            w_mx = r_aq;
            w_mn = r_ai;
        end
        w_mag = w_mx + (w_mn >> 2) + (w_mn >> 3);
    end

    // Register magnitude and its valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2  <= 1'b0;
            r_mag <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) r_mag <= w_mag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: window reduction
    // ------------------------------------------------------------------
`ifdef AMPLITUDE_DETECTOR_PEAK_EN
    localparam int AW = NBITS;
`else
    localparam int AW = NBITS + WBITS;
`endif

    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    w_fold;
    logic [NBITS-1:0] w_result;
    logic [WBITS-1:0] r_cnt;
    logic [NBITS-1:0] r_amp;
    logic             r_next;
    logic             w_last;

    assign w_last = (r_cnt == '1);

    // Fold the current magnitude into the accumulator; the same folded value
    // also yields the window result when this is the last sample.
`ifdef AMPLITUDE_DETECTOR_PEAK_EN
    always_comb begin
        w_fold = r_acc;
        if (r_mag > r_acc) w_fold = r_mag;
        w_result = w_fold;
    end
`else
    always_comb begin
        w_fold   = r_acc + AW'(r_mag);
        w_result = w_fold[AW-1:WBITS];
    end
`endif

    // Window counter, accumulator and held result with its strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_amp  <= '0;
            r_next <= 1'b0;
        end else begin
            r_next <= 1'b0;
            if (r_v2) begin
                if (w_last) begin
                    r_amp  <= w_result;
                    r_next <= 1'b1;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end else begin
                    r_acc <= w_fold;
                    r_cnt <= r_cnt + WBITS'(1);
                end
            end
        end
    end

    assign amplitude = r_amp;
    assign next      = r_next;
    assign win_pos   = r_cnt;

endmodule

// File: tb/tb_amplitude_detector.sv
// Self-checking bench for amplitude_detector (NBITS=16, WBITS=4).
// Expected window results are pushed to a scoreboard queue with the cycle in
// which next must appear; every cycle the outputs are compared on the
// falling edge. Build with +define+AMPLITUDE_DETECTOR_PEAK_EN for peak mode.
module tb_amplitude_detector;

    localparam int NBITS = 16;
    localparam int WBITS = 4;
    localparam int WIN   = 1 << WBITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [NBITS-1:0] i_data;
    logic [NBITS-1:0] q_data;
    logic [NBITS-1:0] amplitude;
    logic             next;
    logic [WBITS-1:0] win_pos;

    amplitude_detector #(.NBITS(NBITS), .WBITS(WBITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .i_data   (i_data),
        .q_data   (q_data),
        .amplitude(amplitude),
        .next     (next),
        .win_pos  (win_pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned amp;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    // model state
    int unsigned m_n    = 0;
    int unsigned m_acc  = 0;
    int unsigned exp_amp = 0;
    int unsigned exp_wp  = 0;
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned model_mag(input int i, input int q);
        int unsigned ai, aq, mx, mn;
        ai = (i < 0) ? int'(-i) : i;
        aq = (q < 0) ? int'(-q) : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        return mx + mn / 4 + mn / 8;
    endfunction

    // One clock cycle: apply inputs, update the model at the capturing edge,
    // then compare every output on the falling edge.
    task automatic drive(input logic r, input logic v, input int i, input int q);
        int unsigned mag;
        logic        exp_next;
        rst      = r;
        in_valid = v;
        i_data   = 16'(i);
        q_data   = 16'(q);
        @(posedge clk);
        cyc++;
        if (r) begin
            sb.delete();
            m_n     = 0;
            m_acc   = 0;
            exp_amp = 0;
            exp_wp  = 0;
            p1      = 1'b0;
            p2      = 1'b0;
        end else begin
            if (p2) exp_wp = (exp_wp + 1) % WIN;
            p2 = p1;
            p1 = v;
            if (v) begin
                mag = model_mag(i, q);
`ifdef AMPLITUDE_DETECTOR_PEAK_EN
                if (mag > m_acc) m_acc = mag;
`else
                m_acc = m_acc + mag;
`endif
                m_n++;
                if (m_n == WIN) begin
`ifdef AMPLITUDE_DETECTOR_PEAK_EN
                    sb.push_back('{amp: m_acc, due: cyc + 2});
`else
                    sb.push_back('{amp: m_acc / WIN, due: cyc + 2});
`endif
                    m_n   = 0;
                    m_acc = 0;
                end
            end
        end
        @(negedge clk);
        exp_next = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_next = 1'b1;
            exp_amp  = sb[0].amp;
            void'(sb.pop_front());
        end
        check_val("next", next, exp_next);
        check_val("amplitude", amplitude, exp_amp);
        check_val("win_pos", win_pos, exp_wp);
    endtask

    task automatic run_window(input int i, input int q);
        for (int k = 0; k < WIN; k++) drive(1'b0, 1'b1, i, q);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int unsigned got_valid;
        rst      = 1'b1;
        in_valid = 1'b0;
        i_data   = '0;
        q_data   = '0;
        @(negedge clk);

        // reset held 3 cycles with random valid inputs
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, int'($urandom), int'($urandom));
        idle(1);

        // constant tone, two back-to-back windows
        run_window(1000, 0);
        run_window(1000, 0);
        idle(3);
        check_val("tone_amp", amplitude, 1000);

        // magnitude arithmetic
        run_window(-800, 400);
        idle(3);
        check_val("mag_950", amplitude, 950);
        run_window(-32768, -32768);
        idle(3);
        check_val("mag_full_scale", amplitude, 45056);

        // mode check
        for (int k = 0; k < WIN - 1; k++) drive(1'b0, 1'b1, 100, 0);
        drive(1'b0, 1'b1, 1700, 0);
        idle(3);
`ifdef AMPLITUDE_DETECTOR_PEAK_EN
        check_val("mode_peak", amplitude, 1700);
`else
        check_val("mode_mean", amplitude, 200);
`endif

        // gapped input, ~30% valid
        got_valid = 0;
        while (got_valid < WIN) begin
            if ($urandom_range(0, 9) < 3) begin
                drive(1'b0, 1'b1, 300, 0);
                got_valid++;
            end else begin
                drive(1'b0, 1'b0, int'($urandom), int'($urandom));
            end
        end
        idle(3);
        check_val("gapped_amp", amplitude, 300);

        // reset mid-window discards the partial window
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 900, 0);
        drive(1'b1, 1'b1, 900, 0);
        check_val("rst_mid_amp", amplitude, 0);
        run_window(500, 0);
        idle(3);
        check_val("post_rst_amp", amplitude, 500);

        // reset just before a due strobe suppresses it
        run_window(700, 0);
        drive(1'b1, 1'b0, 0, 0);
        idle(3);
        check_val("suppressed_amp", amplitude, 0);

        idle(4);
        check_val("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
